// File: rtl/dtcm_ctrl_pkg.sv
// Shared constants and types for the data-TCM responder (dtcm_ctrl and its SRAM).
// Default geometry matches the core: XLEN-wide words, 10-bit word address, 1024 words.
package dtcm_ctrl_pkg;

  localparam int XLEN            = 32;
  localparam int DTCM_ADDR_WIDTH = 10;
  localparam int DTCM_DEPTH      = 1024;

  // Response FIFO depth used when the optional response buffering is built.
  localparam int RSP_FIFO_DP     = 2;

  // Base single-response controller: either nothing pending or one response on the bus.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } rsp_state_e;

endpackage : dtcm_ctrl_pkg

// File: rtl/dtcm_ctrl_sram.sv
// Behavioural single-port data TCM array: synchronous read, per-byte write enables.
// The read register only updates on an enabled read, so its output holds between reads.
module dtcm_sram
  import dtcm_ctrl_pkg::*;
#(
  parameter int DW    = XLEN,
  parameter int AW    = DTCM_ADDR_WIDTH,
  parameter int DEPTH = DTCM_DEPTH
) (
  input  logic            clk,
  input  logic            cs,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wmask,
  output logic [DW-1:0]   rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] idx;

  assign idx = addr[IW-1:0];

  // NOTE: the array and its read register carry no reset; SRAM macros cannot be
  // cleared in one cycle and callers never consume data they did not write.
  always_ff @(posedge clk) begin
    if (cs && we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wmask[i]) begin
          // NOTE: non-blocking so every byte lane and the read register update
          // together at the edge, independent of statement order.
          mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    if (cs && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule : dtcm_sram

// File: rtl/dtcm_ctrl.sv
// Responder end of the LSU<->DTCM cmd/rsp interface; one in-order response per command.
// Define DTCM_RSP_FIFO_EN to add a 2-entry response FIFO so one stalled cycle on rsp does not block cmd.
module dtcm_ctrl
  import dtcm_ctrl_pkg::*;
#(
  parameter int DW    = XLEN,
  parameter int AW    = DTCM_ADDR_WIDTH,
  parameter int DEPTH = DTCM_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dtcm_cmd_valid,
  output logic            dtcm_cmd_ready,
  input  logic            dtcm_cmd_read,
  input  logic [AW-1:0]   dtcm_cmd_addr,
  input  logic [DW-1:0]   dtcm_cmd_wdata,
  input  logic [DW/8-1:0] dtcm_cmd_wmask,
  output logic            dtcm_rsp_valid,
  input  logic            dtcm_rsp_ready,
  output logic [DW-1:0]   dtcm_rsp_rdata,
  output logic            dtcm_rsp_err
);

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic          accept;
  logic          in_range;
  logic          sram_cs;
  logic [DW-1:0] sram_rdata;
  logic [DW-1:0] st_rdata;
  logic          st_load;
  logic          st_err;

  assign in_range = {1'b0, dtcm_cmd_addr} < DEPTH_LIM;
  assign accept   = dtcm_cmd_valid & dtcm_cmd_ready;

  // cmd_ready is high during reset, so the array must be fenced off from rst directly.
  assign sram_cs  = accept & in_range & ~rst;

  dtcm_sram #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .cs    (sram_cs),
    .we    (~dtcm_cmd_read),
    .addr  (dtcm_cmd_addr),
    .wdata (dtcm_cmd_wdata),
    .wmask (dtcm_cmd_wmask),
    .rdata (sram_rdata)
  );

  // Attributes of the most recently accepted command, aligned with the SRAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_load <= 1'b0;
      st_err  <= 1'b0;
    end else if (accept) begin
      st_load <= dtcm_cmd_read & in_range;
      st_err  <= ~in_range;
    end
  end

  assign st_rdata = st_load ? sram_rdata : '0;

`ifdef DTCM_RSP_FIFO_EN

  logic          st_valid;
  logic [DW:0]   fifo_mem [RSP_FIFO_DP];
  logic          fifo_wptr;
  logic          fifo_rptr;
  logic [1:0]    fifo_cnt;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          rsp_pop;
  logic [2:0]    occupancy;

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign rsp_pop    = dtcm_rsp_valid & dtcm_rsp_ready;
  assign fifo_pop   = rsp_pop & ~fifo_empty;
  // The stage bypasses to the bus only when it is the oldest entry and is consumed now.
  assign fifo_push  = st_valid & ~(fifo_empty & rsp_pop);
  assign occupancy  = {2'b00, st_valid} + {1'b0, fifo_cnt};

  assign dtcm_cmd_ready = (occupancy < 3'd2) | rsp_pop;
  assign dtcm_rsp_valid = st_valid | ~fifo_empty;
  assign {dtcm_rsp_err, dtcm_rsp_rdata} = fifo_empty ? {st_err, st_rdata} : fifo_mem[fifo_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid  <= 1'b0;
      fifo_wptr <= 1'b0;
      fifo_rptr <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      st_valid <= accept;
      if (fifo_push) fifo_wptr <= ~fifo_wptr;
      if (fifo_pop)  fifo_rptr <= ~fifo_rptr;
      fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wptr] <= {st_err, st_rdata};
  end

`else

  rsp_state_e state;
  rsp_state_e state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt      = state;
    dtcm_cmd_ready = 1'b1;
    dtcm_rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_RSP;
      end
      ST_RSP: begin
        dtcm_rsp_valid = 1'b1;
        dtcm_cmd_ready = dtcm_rsp_ready;
        if (dtcm_rsp_ready && !accept) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dtcm_rsp_rdata = st_rdata;
  assign dtcm_rsp_err   = st_err;

`endif

endmodule : dtcm_ctrl

// File: tb/tb_dtcm_ctrl.sv
// Self-checking bench for dtcm_ctrl: directed vector table, stall/reset sequences, random traffic
// against a queue-and-array reference model. Builds for either response-buffer configuration.
module tb_dtcm_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 1024;
  localparam int MW    = DW/8;
`ifdef DTCM_RSP_FIFO_EN
  localparam int CAP   = 2;
`else
  localparam int CAP   = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  dtcm_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .dtcm_cmd_valid (cmd_valid),
    .dtcm_cmd_ready (cmd_ready),
    .dtcm_cmd_read  (cmd_read),
    .dtcm_cmd_addr  (cmd_addr),
    .dtcm_cmd_wdata (cmd_wdata),
    .dtcm_cmd_wmask (cmd_wmask),
    .dtcm_rsp_valid (rsp_valid),
    .dtcm_rsp_ready (rsp_ready),
    .dtcm_rsp_rdata (rsp_rdata),
    .dtcm_rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  typedef struct {
    logic          read;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            accepted = 0;
  logic [DW-1:0] mem_model [DEPTH];
  rsp_t          exp_q [$];
  vec_t          vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pre(input int a);
    return 32'hA500_0000 ^ (DW'(a) * 32'h0001_0203);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r = old;
    for (int i = 0; i < MW; i++) if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic vec_t mk(input logic rd, input int a, input logic [DW-1:0] wd,
                              input logic [MW-1:0] m, input logic [DW-1:0] er, input logic ee);
    vec_t v;
    v.read = rd; v.addr = AW'(a); v.wdata = wd; v.mask = m; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input logic v, input logic rd, input int a,
                       input logic [DW-1:0] wd, input logic [MW-1:0] m);
    cmd_valid = v; cmd_read = rd; cmd_addr = AW'(a); cmd_wdata = wd; cmd_wmask = m;
  endtask

  // One clock: check outputs against the model at negedge, then advance the model by the
  // handshakes seen and return just after the rising edge.
  task automatic step();
    int   occ;
    logic fire_cmd;
    logic fire_rsp;
    rsp_t r;
    @(negedge clk);
    if (rst) exp_q.delete();
    occ = exp_q.size();
    check("rsp_valid", 64'(rsp_valid), 64'(occ > 0));
    check("cmd_ready", 64'(cmd_ready), 64'((occ < CAP) || (occ > 0 && rsp_ready)));
    if (occ > 0) begin
      check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
      check("rsp_err",   64'(rsp_err),   64'(exp_q[0].err));
    end
    fire_cmd = cmd_valid && cmd_ready;
    fire_rsp = rsp_valid && rsp_ready;
    if (!rst) begin
      if (fire_rsp && exp_q.size() > 0) void'(exp_q.pop_front());
      if (fire_cmd) begin
        accepted++;
        r = '0;
        if (int'(cmd_addr) >= DEPTH)  r.err = 1'b1;
        else if (cmd_read)            r.rdata = mem_model[int'(cmd_addr)];
        else mem_model[int'(cmd_addr)] = merge(mem_model[int'(cmd_addr)], cmd_wdata, cmd_wmask);
        exp_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a;
    int acc0;
    logic [DW-1:0] held;

    rst = 1'b1; rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 0, '0, '0);
    #2;
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    check("reset_rdata",     64'(rsp_rdata), 64'(0));
    check("reset_err",       64'(rsp_err),   64'(0));
    step(); step();
    rst = 1'b0;
    step();

    // Preload every address the random phase may read.
    for (int i = 0; i < 24; i++) begin
      a = (i < 16) ? i : 1000 + i;
      drive(1'b1, 1'b0, a, pre(a), '1);
      step();
    end
    drive(1'b0, 1'b1, 0, '0, '0);
    step();

    vecs.push_back(mk(1'b0, 4,    32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0));
    vecs.push_back(mk(1'b1, 4,    32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(1'b0, 4,    32'h0000_00AA, 4'h1, 32'h0,         1'b0));
    vecs.push_back(mk(1'b1, 4,    32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0));
    vecs.push_back(mk(1'b1, 1024, 32'h0,         4'h0, 32'h0,         1'b1));
    vecs.push_back(mk(1'b0, 1024, 32'h1234_5678, 4'hF, 32'h0,         1'b1));
    vecs.push_back(mk(1'b1, 2047, 32'h0,         4'h0, 32'h0,         1'b1));
    vecs.push_back(mk(1'b0, 4,    32'h1122_3344, 4'h0, 32'h0,         1'b0));
    vecs.push_back(mk(1'b1, 4,    32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0));
    vecs.push_back(mk(1'b0, 5,    32'hCAFE_0000, 4'hC, 32'h0,         1'b0));
    vecs.push_back(mk(1'b1, 5,    32'h0,         4'h0, {16'hCAFE, pre(5)[15:0]}, 1'b0));
    vecs.push_back(mk(1'b1, 1023, 32'h0,         4'h0, pre(1023),     1'b0));

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].read, int'(vecs[i].addr), vecs[i].wdata, vecs[i].mask);
      step();
      check($sformatf("vec%0d_valid", i), 64'(rsp_valid), 64'(1));
      check($sformatf("vec%0d_rdata", i), 64'(rsp_rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i),   64'(rsp_err),   64'(vecs[i].exp_err));
    end
    drive(1'b0, 1'b1, 0, '0, '0);
    step();

    // Back-to-back loads at full throughput.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, i, '0, '0);
      step();
      check($sformatf("b2b%0d_valid", i), 64'(rsp_valid), 64'(1));
      check($sformatf("b2b%0d_rdata", i), 64'(rsp_rdata), 64'(pre(i)));
    end
    drive(1'b0, 1'b1, 0, '0, '0);
    step();

    // Three cycles of response backpressure on a pending load.
    drive(1'b1, 1'b1, 3, '0, '0);
    step();
    held = rsp_rdata;
    check("stall_first_rdata", 64'(held), 64'(pre(3)));
    rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 6, '0, '0);
    acc0 = accepted;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 64'(rsp_valid), 64'(1));
      check("stall_rdata", 64'(rsp_rdata), 64'(pre(3)));
      check("stall_err",   64'(rsp_err),   64'(0));
    end
    check("stall_accepts", 64'(accepted - acc0), 64'(CAP - 1));
    drive(1'b0, 1'b1, 0, '0, '0);
    rsp_ready = 1'b1;
    repeat (3) step();

    // Reset while a response is stalled; the store presented during reset is discarded.
    drive(1'b1, 1'b1, 7, '0, '0);
    step();
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 0, '0, '0);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b0, 7, 32'hBAD0_BAD0, 4'hF);
    step();
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    rst = 1'b0; rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 0, '0, '0);
    step();
    drive(1'b1, 1'b1, 7, '0, '0);
    step();
    check("rst_no_write", 64'(rsp_rdata), 64'(pre(7)));
    drive(1'b0, 1'b1, 0, '0, '0);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom_range(1024, 2047);
        1, 2:    a = $urandom_range(1016, 1023);
        default: a = $urandom_range(0, 15);
      endcase
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, $urandom, MW'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drive(1'b0, 1'b1, 0, '0, '0);
    rsp_ready = 1'b1;
    repeat (4) step();
    check("drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dtcm_ctrl
